// File: rtl/gf_pkg.sv
// Field constants, FSM state type and counter-width helper for the
// sequential GF(2^M) divider. Default field is the NIST B-163/K-163
// pentanomial z^163 + z^7 + z^6 + z^3 + 1.
package gf_pkg;

    localparam int GF_M = 163;

    localparam logic [GF_M:0] GF_POLY = (164'd1 << 163) | 164'hC9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Step counter must hold values up to 4*M inclusive.
    function automatic int gf_cw(input int m);
        return $clog2(4 * m + 1);
    endfunction

endpackage

// File: rtl/gf2m_half.sv
// Combinational field halving: g * z^-1 mod f(z).
// An odd g is first made even by adding f; bit M of that sum lands in bit M-1.
module gf2m_half
    import gf_pkg::*;
#(
    parameter int         M    = GF_M,
    parameter logic [M:0] POLY = GF_POLY
) (
    input  logic [M-1:0] g,
    output logic [M-1:0] h
);

    // Shift right, folding in f(z)/z when g has a constant term.
    always_comb begin
        h = {1'b0, g[M-1:1]};
        if (g[0]) begin
            h = {1'b0, g[M-1:1]} ^ POLY[M:1];
        end
    end

endmodule

// File: rtl/gf2m_div_seq.sv
// Sequential GF(2^M) divider, q = x / y mod f(z), via the binary extended
// Euclidean algorithm with one reduction step per clock.
// Optional build macro GF_DIV_CYCLE_COUNT_EN adds the run_cycles output
// (number of RUN cycles of the last operation) and its step counter.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one Euclid reduction step per cycle
// DONE  | result held on q/div_zero until out_ready
module gf2m_div_seq
    import gf_pkg::*;
#(
    parameter int         M    = GF_M,
    parameter logic [M:0] POLY = GF_POLY
`ifdef GF_DIV_CYCLE_COUNT_EN
    ,
    parameter int         CW   = gf_cw(M)
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [M-1:0]  x,
    input  logic [M-1:0]  y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [M-1:0]  q,
    output logic          div_zero
`ifdef GF_DIV_CYCLE_COUNT_EN
    ,
    output logic [CW-1:0] run_cycles
`endif
);

    localparam logic [M:0] ONE = (M + 1)'(1);

    div_state_t   state, state_nxt;
    logic [M:0]   u, u_nxt;
    logic [M:0]   v, v_nxt;
    logic [M-1:0] g1, g1_nxt;
    logic [M-1:0] g2, g2_nxt;
    logic [M-1:0] q_nxt;
    logic         div_zero_nxt;
    logic [M-1:0] g1_half;
    logic [M-1:0] g2_half;

`ifdef GF_DIV_CYCLE_COUNT_EN
    logic [CW-1:0] step, step_nxt;
    logic [CW-1:0] run_cycles_nxt;
`endif

    gf2m_half #(.M(M), .POLY(POLY)) u_half_g1 (
        .g (g1),
        .h (g1_half)
    );

    gf2m_half #(.M(M), .POLY(POLY)) u_half_g2 (
        .g (g2),
        .h (g2_half)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake outputs and next datapath values.
    always_comb begin
        state_nxt    = state;
        u_nxt        = u;
        v_nxt        = v;
        g1_nxt       = g1;
        g2_nxt       = g2;
        q_nxt        = q;
        div_zero_nxt = div_zero;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
`ifdef GF_DIV_CYCLE_COUNT_EN
        step_nxt       = step;
        run_cycles_nxt = run_cycles;
`endif

        unique case (state)
            IDLE: begin
                // Held low while reset is applied so the first accept
                // can only happen after release.
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    u_nxt  = {1'b0, y};
                    v_nxt  = POLY;
                    g1_nxt = x;
                    g2_nxt = '0;
`ifdef GF_DIV_CYCLE_COUNT_EN
                    step_nxt       = '0;
                    run_cycles_nxt = '0;
`endif
                    if (y == '0) begin
                        q_nxt        = '0;
                        div_zero_nxt = 1'b1;
                        state_nxt    = DONE;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end

            RUN: begin
`ifdef GF_DIV_CYCLE_COUNT_EN
                step_nxt = step + 1'b1;
`endif
                if (u == ONE) begin
                    q_nxt        = g1;
                    div_zero_nxt = 1'b0;
                    state_nxt    = DONE;
`ifdef GF_DIV_CYCLE_COUNT_EN
                    run_cycles_nxt = step + 1'b1;
`endif
                end else if (v == ONE) begin
                    q_nxt        = g2;
                    div_zero_nxt = 1'b0;
                    state_nxt    = DONE;
`ifdef GF_DIV_CYCLE_COUNT_EN
                    run_cycles_nxt = step + 1'b1;
`endif
                end else if (!u[0]) begin
                    u_nxt  = u >> 1;
                    g1_nxt = g1_half;
                end else if (!v[0]) begin
                    v_nxt  = v >> 1;
                    g2_nxt = g2_half;
                end else if (u > v) begin
                    // Plain magnitude compare stands in for a degree
                    // compare; equal degrees are fine either way.
                    u_nxt  = u ^ v;
                    g1_nxt = g1 ^ g2;
                end else begin
                    v_nxt  = v ^ u;
                    g2_nxt = g2 ^ g1;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and result registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            u        <= '0;
            v        <= '0;
            g1       <= '0;
            g2       <= '0;
            q        <= '0;
            div_zero <= 1'b0;
        end else begin
            u        <= u_nxt;
            v        <= v_nxt;
            g1       <= g1_nxt;
            g2       <= g2_nxt;
            q        <= q_nxt;
            div_zero <= div_zero_nxt;
        end
    end

`ifdef GF_DIV_CYCLE_COUNT_EN
    // RUN-cycle counter and its latched copy for the last result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step       <= '0;
            run_cycles <= '0;
        end else begin
            step       <= step_nxt;
            run_cycles <= run_cycles_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_gf2m_div_seq.sv
// Self-checking bench for gf2m_div_seq: a GF(2^8) AES-field instance and the
// default GF(2^163) instance, checked against a bit-serial field multiplier.
module tb_gf2m_div_seq;
    import gf_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // GF(2^8) instance
    logic       iv8 = 1'b0, ir8, ov8, or8 = 1'b0, dz8;
    logic [7:0] x8 = '0, y8 = '0, q8;
    // GF(2^163) instance
    logic         iva = 1'b0, ira, ova, ora = 1'b0, dza;
    logic [162:0] xa = '0, ya = '0, qa;

`ifdef GF_DIV_CYCLE_COUNT_EN
    logic [gf_cw(8)-1:0]   rc8;
    logic [gf_cw(163)-1:0] rca;
`endif

    gf2m_div_seq #(.M(8), .POLY(9'h11B)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .x(x8), .y(y8), .out_valid(ov8), .out_ready(or8), .q(q8), .div_zero(dz8)
`ifdef GF_DIV_CYCLE_COUNT_EN
        , .run_cycles(rc8)
`endif
    );

    gf2m_div_seq u_d163 (
        .clk(clk), .rst_n(rst_n), .in_valid(iva), .in_ready(ira),
        .x(xa), .y(ya), .out_valid(ova), .out_ready(ora), .q(qa), .div_zero(dza)
`ifdef GF_DIV_CYCLE_COUNT_EN
        , .run_cycles(rca)
`endif
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] mul8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = '0;
        for (int i = 7; i >= 0; i--) begin
            r = r[7] ? ((r << 1) ^ 8'h1B) : (r << 1);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic logic [162:0] mul163(input logic [162:0] a, input logic [162:0] b);
        logic [162:0] r = '0;
        for (int i = 162; i >= 0; i--) begin
            r = r[162] ? ((r << 1) ^ 163'hC9) : (r << 1);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    // Quotient by exhaustive search: the unique q with q*y == x.
    function automatic logic [7:0] div8_ref(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] c;
        for (int i = 0; i < 256; i++) begin
            c = 8'(i);
            if (mul8(c, b) == a) return c;
        end
        return 8'h00;
    endfunction

    function automatic logic [162:0] rand163();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[162:0];
    endfunction

    // ---------------- drivers (no checking) ----------------
    task automatic op8(input logic [7:0] xi, input logic [7:0] yi,
                       output logic [7:0] qo, output logic dzo,
                       output int k, output logic acc, output int rc);
        @(negedge clk);
        acc = ir8;
        x8 = xi; y8 = yi; iv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom);
        k = 0;
        while (!ov8 && k <= 40) begin
            k++;
            @(negedge clk);
        end
        qo = q8; dzo = dz8;
`ifdef GF_DIV_CYCLE_COUNT_EN
        rc = int'(rc8);
`else
        rc = k;
`endif
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
    endtask

    task automatic op163(input logic [162:0] xi, input logic [162:0] yi,
                         output logic [162:0] qo, output logic dzo,
                         output int k, output logic acc, output int rc);
        @(negedge clk);
        acc = ira;
        xa = xi; ya = yi; iva = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iva = 1'b0; xa = rand163(); ya = rand163();
        k = 0;
        while (!ova && k <= 660) begin
            k++;
            @(negedge clk);
        end
        qo = qa; dzo = dza;
`ifdef GF_DIV_CYCLE_COUNT_EN
        rc = int'(rca);
`else
        rc = k;
`endif
        ora = 1'b1;
        @(negedge clk);
        ora = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ir8 !== 1'b0) begin failures++; $display("FAIL reset_in_ready8 got=%b exp=0", ir8); end
        checks++; if (ira !== 1'b0) begin failures++; $display("FAIL reset_in_ready163 got=%b exp=0", ira); end
        checks++; if (ova !== 1'b0 || ov8 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b/%b exp=0", ova, ov8); end
        checks++; if (qa !== '0 || q8 !== '0) begin failures++; $display("FAIL reset_q got=%h/%h exp=0", qa, q8); end
        checks++; if (dza !== 1'b0 || dz8 !== 1'b0) begin failures++; $display("FAIL reset_div_zero got=%b/%b exp=0", dza, dz8); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (ira !== 1'b1 || ir8 !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b/%b exp=1", ira, ir8); end
    endtask

    task automatic test_vectors8();
        logic [7:0] tx [3] = '{8'h01, 8'h57, 8'hA5};
        logic [7:0] ty [3] = '{8'h53, 8'h57, 8'h01};
        logic [7:0] tq [3] = '{8'hCA, 8'h01, 8'hA5};
        logic [7:0] qo; logic dzo, acc; int k, rc;
        for (int i = 0; i < 3; i++) begin
            op8(tx[i], ty[i], qo, dzo, k, acc, rc);
            checks++; if (acc !== 1'b1) begin failures++; $display("FAIL vec8_in_ready[%0d] got=%b exp=1", i, acc); end
            checks++; if (qo !== tq[i]) begin failures++; $display("FAIL vec8_q[%0d] got=%h exp=%h", i, qo, tq[i]); end
            checks++; if (dzo !== 1'b0) begin failures++; $display("FAIL vec8_div_zero[%0d] got=%b exp=0", i, dzo); end
            checks++; if (rc !== k) begin failures++; $display("FAIL vec8_run_cycles[%0d] got=%0d exp=%0d", i, rc, k); end
        end
        checks++; if (k !== 1) begin failures++; $display("FAIL vec8_y1_run_len got=%0d exp=1", k); end
    endtask

    task automatic test_random8();
        logic [7:0] xi, yi, qo, qe; logic dzo, acc; int k, rc;
        for (int n = 0; n < 200; n++) begin
            xi = 8'($urandom);
            yi = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            qe = (yi == 8'h00) ? 8'h00 : div8_ref(xi, yi);
            op8(xi, yi, qo, dzo, k, acc, rc);
            checks++;
            if (qo !== qe || dzo !== (yi == 8'h00) || k > 32 || rc !== k) begin
                failures++;
                $display("FAIL rand8 x=%h y=%h got q=%h dz=%b cyc=%0d rc=%0d exp q=%h dz=%b cyc<=32",
                         xi, yi, qo, dzo, k, rc, qe, (yi == 8'h00));
            end
        end
    endtask

    task automatic test_zero163();
        logic [162:0] qo; logic dzo, acc; int k, rc;
        op163(rand163(), '0, qo, dzo, k, acc, rc);
        checks++; if (qo !== '0 || dzo !== 1'b1) begin failures++; $display("FAIL y0_result got q=%h dz=%b exp q=0 dz=1", qo, dzo); end
        checks++; if (k !== 0 || rc !== 0) begin failures++; $display("FAIL y0_latency got run=%0d rc=%0d exp 0", k, rc); end
        op163('0, 163'd5, qo, dzo, k, acc, rc);
        checks++; if (qo !== '0 || dzo !== 1'b0) begin failures++; $display("FAIL x0_result got q=%h dz=%b exp q=0 dz=0", qo, dzo); end
    endtask

    task automatic test_random163();
        logic [162:0] xi, yi, qo; logic dzo, acc; int k, rc;
        for (int n = 0; n < 60; n++) begin
            xi = rand163();
            yi = rand163();
            if (n < 4) yi = 163'(1) << (n * 50);
            if (yi == '0) yi = 163'd1;
            op163(xi, yi, qo, dzo, k, acc, rc);
            checks++;
            if (mul163(qo, yi) !== xi || dzo !== 1'b0 || acc !== 1'b1) begin
                failures++;
                $display("FAIL rand163_product y=%h got q=%h dz=%b exp q*y=x=%h", yi, qo, dzo, xi);
            end
            checks++;
            if (k > 652 || rc !== k) begin
                failures++;
                $display("FAIL rand163_run_bound got run=%0d rc=%0d exp <=652", k, rc);
            end
        end
    endtask

    task automatic test_stall();
        logic [162:0] xi, yi, q0; logic dz0; int k;
        xi = rand163(); yi = rand163() | 163'd1;
        @(negedge clk);
        xa = xi; ya = yi; iva = 1'b1;
        @(posedge clk);
        @(negedge clk);
        xa = rand163(); ya = rand163() | 163'd2;
        k = 0;
        while (!ova && k <= 660) begin k++; @(negedge clk); end
        checks++; if (ova !== 1'b1) begin failures++; $display("FAIL stall_done_timeout got out_valid=%b exp=1", ova); end
        q0 = qa; dz0 = dza;
        checks++; if (mul163(q0, yi) !== xi || dz0 !== 1'b0) begin failures++; $display("FAIL stall_result got q=%h exp q*y=%h", q0, xi); end
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            checks++;
            if (qa !== q0 || ova !== 1'b1 || dza !== dz0 || ira !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d] got q=%h ov=%b dz=%b ir=%b exp q=%h ov=1 dz=%b ir=0",
                         c, qa, ova, dza, ira, q0, dz0);
            end
        end
        iva = 1'b0; ora = 1'b1;
        @(negedge clk);
        ora = 1'b0;
        checks++; if (ova !== 1'b0 || ira !== 1'b1) begin failures++; $display("FAIL stall_release got ov=%b ir=%b exp ov=0 ir=1", ova, ira); end
        repeat (3) @(negedge clk);
        checks++; if (ova !== 1'b0) begin failures++; $display("FAIL busy_valid_not_queued got ov=%b exp=0", ova); end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        xa = rand163(); ya = rand163() | (163'd1 << 160) | 163'd1; iva = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iva = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (ova !== 1'b0 || qa !== '0 || ira !== 1'b0) begin failures++; $display("FAIL midrun_reset got ov=%b q=%h ir=%b exp ov=0 q=0 ir=0", ova, qa, ira); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (ira !== 1'b1 || ova !== 1'b0) begin failures++; $display("FAIL midrun_release got ir=%b ov=%b exp ir=1 ov=0", ira, ova); end
        repeat (20) @(negedge clk);
        checks++; if (ova !== 1'b0 || qa !== '0) begin failures++; $display("FAIL midrun_aborted got ov=%b q=%h exp ov=0 q=0", ova, qa); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] qo; logic dzo, acc; int k, rc;
        for (int i = 1; i < 6; i++) begin
            op8(8'(i * 37), 8'(i * 11), qo, dzo, k, acc, rc);
            checks++;
            if (acc !== 1'b1 || mul8(qo, 8'(i * 11)) !== 8'(i * 37)) begin
                failures++;
                $display("FAIL b2b[%0d] got q=%h acc=%b exp q*y=%h acc=1", i, qo, acc, 8'(i * 37));
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors8();
        test_random8();
        test_zero163();
        test_random163();
        test_stall();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout got=expired exp=finished");
        $fatal(1, "timeout");
    end

endmodule
